mult_div_unit: RTL
==================

Name: mult_div_unit

Overview:
- Iterative 32-bit multiply/divide unit on the EX side, directly downstream of the register file.
- Consumes the two register read-data buses and executes MIPS MULT, MULTU, DIV and DIVU into private HI/LO registers.
- Also serves MTHI and MTLO writes.
- HI/LO are exposed continuously, so the writeback mux can return them to the register file for MFHI and MFLO.

Parameters:
- WIDTH, 32, operand and HI/LO width. Only 32 is supported.
- ITER, 32, number of shift/subtract iterations. It must equal WIDTH.

Ports:
- CLK  input  1  system clock. All state updates on the posedge.
- RST_n  input  1  asynchronous, active-low reset.
- start  input  1  begin the operation selected by op. Sampled only when busy=0.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- srcA  input  32  rs operand (register file readData1).
- srcB  input  32  rt operand (register file readData2).
- mthi  input  1  load HI from srcA. Honoured only when idle.
- mtlo  input  1  load LO from srcA. Honoured only when idle.
- busy  output  1  operation in progress. Upstream must stall MF*/MT*/new start while busy=1.
- done  output  1  one-cycle pulse in the cycle HI/LO first show the result.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
Reset (RST_n=0, asynchronous):
- state=IDLE, busy=0, done=0, hi=0, lo=0.
- Iteration counter and working registers cleared.
- An operation in flight is discarded, and no partial result reaches hi/lo.

State machine:
- IDLE -> RUN on a posedge with start=1 ("edge 0").
  - Latch op, the operand magnitudes and the operand sign bits.
  - Signed ops take two's-complement magnitude. Unsigned ops use the value as-is.
  - count=0; busy=1 from the next cycle.
- RUN: one iteration per posedge, count increments.
  - Multiply: 64-bit shift-add on magnitudes.
  - Divide: restoring shift-subtract on magnitudes, giving quotient and remainder.
  - On the edge where count reaches 31 (edge 32), go to FIN.
- FIN (edge 33): apply sign correction, write hi/lo, done=1 for exactly one cycle, busy=0, go to IDLE.
- Fixed latency: result visible 34 cycles after the start edge (start at edge 0, result after edge 33). The count is identical for all four ops, including divide-by-zero.

Sign rules:
- MULT: product negated if srcA[31]^srcB[31]. hi=product[63:32], lo=product[31:0].
- DIV: quotient negated if signs differ; remainder takes the sign of the dividend. lo=quotient, hi=remainder.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (natural wrap, no trap).

Boundary conditions:
- Divide by zero (srcB=0, DIV or DIVU): hi=srcA as given, lo=0xFFFFFFFF. Full latency still applies, no exception.
- start while busy=1: ignored. Operands and op are not re-latched.
- mthi/mtlo while busy=1: ignored.
- mthi/mtlo while idle with start=0: the register loads from srcA at the next posedge. mthi and mtlo together load both.
- start=1 together with mthi/mtlo while idle: start wins, mthi/mtlo dropped.
- start held high continuously: a new op begins on the first IDLE edge after done. The done cycle itself is IDLE, so back-to-back ops are spaced 35 cycles apart.
- hi/lo hold their previous values for the whole of RUN. They change only in FIN, on MT*, or on reset.

Test Plan:
- MULT srcA=0xFFFFFFFD (-3), srcB=7 -> done at edge 33, hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high over edges 1..33 exactly.
- MULTU srcA=srcB=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV srcA=0xFFFFFFF9 (-7), srcB=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU srcA=100, srcB=0 -> hi=0x00000064, lo=0xFFFFFFFF after the same 34-cycle latency.
- mthi with srcA=0x12345678 while idle -> hi=0x12345678 next edge. Then start MULTU 2x3 and pulse mtlo plus a second start mid-run -> both ignored, final hi=0, lo=6.
- Start DIV 50/7, assert RST_n=0 at edge 10 -> busy=0, hi=lo=0 immediately (asynchronous). After release, no done pulse appears.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative MIPS HI/LO unit: MULT/MULTU/DIV/DIVU plus MTHI/MTLO, 34 cycles from start edge to result.
// busy is high from the cycle after start until the done cycle; start/mthi/mtlo are ignored while busy.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t state;
  state_t nextState;

  logic [CW-1:0]      count;
  logic               isDiv;
  logic               negRes;
  logic               negRem;
  logic               divZero;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;

  logic               sgnA;
  logic               sgnB;
  logic [WIDTH-1:0]   magA;
  logic [WIDTH-1:0]   magB;

  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH-1:0] mulNext;
  logic [WIDTH:0]     divShift;
  logic [WIDTH+1:0]   divDiff;
  logic               divFits;
  logic [2*WIDTH-1:0] divNext;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   resHi;
  logic [WIDTH-1:0]   resLo;

  assign busy = (state != IDLE);

  // Operand magnitudes; unsigned ops never see a sign bit.
  assign sgnA = ~op[0] & srcA[WIDTH-1];
  assign sgnB = ~op[0] & srcB[WIDTH-1];
  assign magA = sgnA ? (~srcA + 1'b1) : srcA;
  assign magB = sgnB ? (~srcB + 1'b1) : srcB;

  // Multiply step: acc = {partial product, remaining multiplier bits}.
  assign mulSum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mulNext = {mulSum, acc[WIDTH-1:1]};

  // Restoring divide step: acc = {partial remainder, dividend/quotient bits}.
  assign divShift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign divDiff  = {1'b0, divShift} - {2'b00, opnd};
  assign divFits  = ~|divDiff[WIDTH+1:WIDTH];
  assign divNext  = {(divFits ? divDiff[WIDTH-1:0] : divShift[WIDTH-1:0]),
                     acc[WIDTH-2:0], divFits};

  assign prod = negRes ? (~acc + 1'b1) : acc;
  assign quo  = acc[WIDTH-1:0];
  assign rem  = acc[2*WIDTH-1:WIDTH];

  always_comb begin
    resHi = prod[2*WIDTH-1:WIDTH];
    resLo = prod[WIDTH-1:0];
    if (isDiv) begin
      // Remainder follows the dividend sign, which also yields hi=srcA on divide-by-zero.
      resHi = negRem ? (~rem + 1'b1) : rem;
      resLo = divZero ? '1 : (negRes ? (~quo + 1'b1) : quo);
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start) nextState = RUN;
      RUN:     if (count == LAST) nextState = FIN;
      FIN:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      count   <= '0;
      isDiv   <= 1'b0;
      negRes  <= 1'b0;
      negRem  <= 1'b0;
      divZero <= 1'b0;
      opnd    <= '0;
      acc     <= '0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            count   <= '0;
            isDiv   <= op[1];
            negRes  <= sgnA ^ sgnB;
            negRem  <= sgnA;
            divZero <= op[1] & ~|srcB;
            opnd    <= op[1] ? magB : magA;
            acc     <= {{WIDTH{1'b0}}, (op[1] ? magA : magB)};
          end else begin
            if (mthi) hi <= srcA;
            if (mtlo) lo <= srcA;
          end
        end
        RUN: begin
          acc   <= isDiv ? divNext : mulNext;
          count <= count + 1'b1;
        end
        FIN: begin
          hi   <= resHi;
          lo   <= resLo;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
